// File: rtl/memctrl_arb.sv
// memctrl_arb: byte-serial main-memory controller for the CPU core.
//
// It arbitrates between instruction fetch (IF) and the load/store buffer (LS) and drives a
// single-port 8-bit RAM/IO bus. Transfers are 1, 2 or 4 bytes, little-endian. Stores to the
// IO region stall while the UART buffer is full. LS gets at most LS_BURST_MAX consecutive
// grants while IF is waiting.
//
// Optional feature macro: MEMCTRL_SIGN_EXT_EN
//   When it is defined, byte/half loads with ls_unsigned=0 are sign-extended. When it is
//   undefined, every load is zero-extended and the LSB does the extension.
//
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (global enable), clear (pipeline flush)
//   mem_din/mem_dout/mem_a/mem_wr : RAM/IO bus (read data valid the cycle after address)
//   io_buffer_full                : UART buffer full, stalls IO-region stores
//   if_enable/inst_addr -> if_ready/inst            : instruction fetch
//   ls_enable/is_write/ls_addr/store_val/ls_size/ls_unsigned -> ls_finished/load_val : LSB
module memctrl_arb #(
  parameter int unsigned MEM_ADDR_BITS = 18,
  parameter logic [31:0] IO_BASE       = 32'h0003_0000,
  parameter int unsigned LS_BURST_MAX  = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_enable,
  input  logic [31:0] inst_addr,
  output logic        if_ready,
  output logic [31:0] inst,
  input  logic        ls_enable,
  input  logic        is_write,
  input  logic [31:0] ls_addr,
  input  logic [31:0] store_val,
  input  logic [1:0]  ls_size,
  input  logic        ls_unsigned,
  output logic        ls_finished,
  output logic [31:0] load_val
);

  localparam logic [31:0] AddrMask = (MEM_ADDR_BITS >= 32) ? 32'hFFFF_FFFF
                                   : ((32'd1 << MEM_ADDR_BITS) - 32'd1);
  localparam logic [3:0]  BurstMax = 4'(LS_BURST_MAX);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic        owner_ls_q, owner_ls_d;
  logic        write_q, write_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  k_q, k_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  burst_q, burst_d;
  logic        held_q, held_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] load_val_q, load_val_d;
`ifdef MEMCTRL_SIGN_EXT_EN
  logic        ld_unsigned_q, ld_unsigned_d;
`else
  logic        unused_ls_unsigned;
  assign unused_ls_unsigned = ls_unsigned;
`endif

  logic [31:0] cur_addr;
  logic [31:0] ext_val;
  logic [1:0]  cap_sel;
  logic        io_stall;
  logic        grant_ls;
  logic        done_pulse;

  function automatic logic [2:0] size_to_k(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign cur_addr   = base_q + 32'(idx_q);
  assign cap_sel    = 2'(idx_q - 3'd1);
  assign io_stall   = (state_q == StWrite) && (base_q >= IO_BASE) && io_buffer_full;
  assign grant_ls   = ls_enable && !((burst_q == BurstMax) && if_enable);
  // A flush during a read's done cycle swallows the pulse; stores always report.
  assign done_pulse = rdy_in && (state_q == StDone) && (write_q || !clear);

  always_comb begin
    ext_val = data_q;
`ifdef MEMCTRL_SIGN_EXT_EN
    if (!ld_unsigned_q) begin
      if (k_q == 3'd1)      ext_val = {{24{data_q[7]}}, data_q[7:0]};
      else if (k_q == 3'd2) ext_val = {{16{data_q[15]}}, data_q[15:0]};
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    owner_ls_d = owner_ls_q;
    write_d    = write_q;
    base_d     = base_q;
    k_d        = k_q;
    idx_d      = idx_q;
    data_d     = data_q;
    burst_d    = burst_q;
    held_d     = held_q;
    inst_d     = inst_q;
    load_val_d = load_val_q;
`ifdef MEMCTRL_SIGN_EXT_EN
    ld_unsigned_d = ld_unsigned_q;
`endif
    if (rdy_in) begin
      unique case (state_q)
        StIdle: begin
          idx_d  = '0;
          held_d = 1'b0;
          if (clear) begin
            burst_d = '0;
          end else if (grant_ls) begin
            state_d    = is_write ? StWrite : StRead;
            owner_ls_d = 1'b1;
            write_d    = is_write;
            base_d     = ls_addr;
            k_d        = size_to_k(ls_size);
            data_d     = is_write ? store_val : '0;
            burst_d    = if_enable ? burst_q + 4'd1 : '0;
`ifdef MEMCTRL_SIGN_EXT_EN
            ld_unsigned_d = ls_unsigned;
`endif
          end else if (if_enable) begin
            state_d    = StRead;
            owner_ls_d = 1'b0;
            write_d    = 1'b0;
            base_d     = inst_addr;
            k_d        = 3'd4;
            data_d     = '0;
            burst_d    = '0;
          end
        end
        StRead: begin
          held_d = 1'b0;
          if (clear) begin
            state_d = StIdle;
            burst_d = '0;
          end else begin
            // mem_din carries the byte addressed in the previous cycle.
            if (idx_q != 3'd0 && !held_q) data_d[{cap_sel, 3'b000} +: 8] = mem_din;
            if (idx_q == k_q) state_d = StDone;
            else              idx_d   = idx_q + 3'd1;
          end
        end
        StWrite: begin
          // A committed store is never abandoned; clear only resets fairness.
          if (clear) burst_d = '0;
          if (!io_stall) begin
            if (idx_q == k_q - 3'd1) state_d = StDone;
            else                     idx_d   = idx_q + 3'd1;
          end
        end
        StDone: begin
          state_d = StIdle;
          if (clear) burst_d = '0;
          if (done_pulse) begin
            if (!owner_ls_q)    inst_d     = data_q;
            else if (!write_q)  load_val_d = ext_val;
          end
        end
      endcase
    end else if (state_q == StRead && idx_q != 3'd0 && !held_q) begin
      // Frozen: the bus keeps the address, so mem_din moves on to the next byte after this
      // cycle. Grab the pending byte now and skip the capture on the resume edge.
      data_d[{cap_sel, 3'b000} +: 8] = mem_din;
      held_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= StIdle;
      owner_ls_q <= 1'b0;
      write_q    <= 1'b0;
      base_q     <= '0;
      k_q        <= 3'd1;
      idx_q      <= '0;
      data_q     <= '0;
      burst_q    <= '0;
      held_q     <= 1'b0;
      inst_q     <= '0;
      load_val_q <= '0;
`ifdef MEMCTRL_SIGN_EXT_EN
      ld_unsigned_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      write_q    <= write_d;
      base_q     <= base_d;
      k_q        <= k_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      burst_q    <= burst_d;
      held_q     <= held_d;
      inst_q     <= inst_d;
      load_val_q <= load_val_d;
`ifdef MEMCTRL_SIGN_EXT_EN
      ld_unsigned_q <= ld_unsigned_d;
`endif
    end
  end

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    // During the final read cycle (idx == k) only the last byte is captured; no address.
    if ((state_q == StRead && idx_q < k_q) || state_q == StWrite) mem_a = cur_addr & AddrMask;
    if (state_q == StWrite) begin
      mem_dout = data_q[{idx_q[1:0], 3'b000} +: 8];
      mem_wr   = rdy_in && !io_stall;
    end
  end

  assign if_ready    = done_pulse && !owner_ls_q;
  assign ls_finished = done_pulse && owner_ls_q;
  assign inst        = if_ready ? data_q : inst_q;
  assign load_val    = (ls_finished && !write_q) ? ext_val : load_val_q;

endmodule

// File: tb/tb_memctrl_arb.sv
module tb_memctrl_arb;
  localparam logic [31:0] IoBase = 32'h0003_0000;
  localparam logic [31:0] AMask  = 32'h0003_FFFF;
  localparam int          BMax   = 2;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, clear, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_enable, if_ready;
  logic [31:0] inst_addr, inst;
  logic        ls_enable, is_write, ls_unsigned, ls_finished;
  logic [31:0] ls_addr, store_val, load_val;
  logic [1:0]  ls_size;

  always #5 clk = ~clk;

  memctrl_arb #(.MEM_ADDR_BITS(18), .IO_BASE(IoBase), .LS_BURST_MAX(BMax)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_enable(if_enable), .inst_addr(inst_addr), .if_ready(if_ready), .inst(inst),
    .ls_enable(ls_enable), .is_write(is_write), .ls_addr(ls_addr), .store_val(store_val),
    .ls_size(ls_size), .ls_unsigned(ls_unsigned), .ls_finished(ls_finished),
    .load_val(load_val)
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- memory environment ----------------
  logic [7:0]  ram [logic [31:0]];
  logic [31:0] a_prev = '0;
  logic [31:0] wa[$];
  logic [7:0]  wd[$];
  logic [31:0] alog[$];
  byte         dlog[$];
  int          wr_cnt = 0, ifr_cnt = 0, lsf_cnt = 0;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    logic [31:0] m;
    m = a & AMask;
    return ram.exists(m) ? ram[m] : 8'h00;
  endfunction

  initial forever begin
    @(negedge clk);
    if (mem_wr === 1'b1) begin
      ram[mem_a & AMask] = mem_dout;
      wa.push_back(mem_a);
      wd.push_back(mem_dout);
      wr_cnt++;
    end
    if (mem_a !== 32'd0 && (alog.size() == 0 || alog[$] !== mem_a)) alog.push_back(mem_a);
    if (if_ready === 1'b1)    begin ifr_cnt++; dlog.push_back(8'h49); end
    if (ls_finished === 1'b1) begin lsf_cnt++; dlog.push_back(8'h4C); end
    a_prev = mem_a & AMask;
  end

  initial begin
    mem_din = '0;
    forever begin
      @(posedge clk);
      #1 mem_din = ram_rd(a_prev);
    end
  end

  // ---------------- transaction-level reference model ----------------
  bit          m_valid = 0, m_busy = 0, m_done = 0, m_ls = 0, m_wr = 0;
  int          m_k = 0, m_beat = 0, m_burst = 0;
  logic [31:0] m_base = '0, m_store = '0, m_result = '0, m_inst = '0, m_load = '0;

  // Value a load must return: the k bytes at base from memory, extended by the rules.
  function automatic logic [31:0] expect_load(input logic [31:0] base, input int k,
                                              input bit uns);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < k; i++) v = v | (32'(ram_rd(base + 32'(i))) << (8 * i));
`ifdef MEMCTRL_SIGN_EXT_EN
    if (!uns && k == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!uns && k == 2 && v[15]) v = v | 32'hFFFF_0000;
`else
    if (uns) v = v;
`endif
    return v;
  endfunction

  function automatic int size_k(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  initial forever begin
    @(posedge clk);
    if (!rst_in) begin
      m_valid = 1; m_busy = 0; m_done = 0; m_burst = 0; m_inst = '0; m_load = '0;
    end else if (rdy_in) begin
      if (!m_busy) begin
        if (clear) m_burst = 0;
        else if (ls_enable && !(m_burst == BMax && if_enable)) begin
          m_busy = 1; m_ls = 1; m_wr = is_write; m_base = ls_addr; m_k = size_k(ls_size);
          m_beat = 0; m_store = store_val;
          m_result = expect_load(ls_addr, m_k, ls_unsigned);
          m_burst = if_enable ? m_burst + 1 : 0;
        end else if (if_enable) begin
          m_busy = 1; m_ls = 0; m_wr = 0; m_base = inst_addr; m_k = 4; m_beat = 0;
          m_result = expect_load(inst_addr, 4, 1'b1);
          m_burst = 0;
        end
      end else if (m_done) begin
        if (m_wr || !clear) begin
          if (!m_ls) m_inst = m_result;
          else if (!m_wr) m_load = m_result;
        end
        if (clear) m_burst = 0;
        m_busy = 0; m_done = 0;
      end else if (!m_wr) begin
        // Reads: k address beats, one capture beat, then done.
        if (clear) begin m_busy = 0; m_burst = 0; end
        else if (m_beat == m_k) m_done = 1;
        else m_beat++;
      end else begin
        if (clear) m_burst = 0;
        if (!(m_base >= IoBase && io_buffer_full)) begin
          if (m_beat == m_k - 1) m_done = 1;
          else m_beat++;
        end
      end
    end
  end

  initial forever begin
    bit          act, pulse;
    logic [31:0] e_a;
    @(negedge clk);
    if (m_valid) begin
      act   = m_busy && !m_done;
      pulse = m_busy && m_done && rdy_in && (m_wr || !clear);
      e_a   = (act && m_beat < m_k) ? ((m_base + 32'(m_beat)) & AMask) : 32'd0;
      chk("mem_a", mem_a, e_a);
      chk("mem_wr", 32'(mem_wr),
          32'(act && m_wr && rdy_in && !(m_base >= IoBase && io_buffer_full)));
      chk("mem_dout", 32'(mem_dout), (act && m_wr) ? 32'(8'(m_store >> (8 * m_beat))) : 32'd0);
      chk("if_ready", 32'(if_ready), 32'(pulse && !m_ls));
      chk("ls_finished", 32'(ls_finished), 32'(pulse && m_ls));
      chk("inst", inst, (pulse && !m_ls) ? m_result : m_inst);
      chk("load_val", load_val, (pulse && m_ls && !m_wr) ? m_result : m_load);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    bit got;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (if_ready === 1'b1 || ls_finished === 1'b1) got = 1;
    end
    chk(nm, 32'(got), 32'd1);
  endtask

  task automatic ls_req(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                        input bit uns, input logic [31:0] v);
    ls_enable = 1; is_write = wr; ls_addr = a; ls_size = sz; ls_unsigned = uns; store_val = v;
  endtask

  task automatic ls_drop();
    ls_enable = 0; is_write = 0;
  endtask

  task automatic do_ls(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                       input bit uns, input logic [31:0] v, input string nm);
    cyc();
    ls_req(wr, a, sz, uns, v);
    wait_done(nm);
    cyc();
    ls_drop();
  endtask

  initial begin
    string order;
    rst_in = 0; rdy_in = 1; clear = 0; io_buffer_full = 0;
    if_enable = 0; inst_addr = '0; ls_enable = 0; is_write = 0; ls_addr = '0;
    store_val = '0; ls_size = '0; ls_unsigned = 0;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
    cyc(); cyc();
    rst_in = 1;
    @(negedge clk);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_if_ready", 32'(if_ready), 0);
    chk("rst_ls_finished", 32'(ls_finished), 0);
    chk("rst_inst", inst, 0);

    // Word fetch
    alog.delete(); wr_cnt = 0;
    cyc();
    if_enable = 1; inst_addr = 32'h100;
    wait_done("fetch_done");
    cyc();
    if_enable = 0;
    chk("fetch_inst", inst, 32'h0010_0513);
    chk("fetch_naddr", 32'(alog.size()), 4);
    for (int i = 0; i < 4 && i < alog.size(); i++) chk("fetch_addr", alog[i], 32'h100 + 32'(i));
    chk("fetch_no_wr", 32'(wr_cnt), 0);

    // Half store then signed half load
    wa.delete(); wd.delete();
    do_ls(1, 32'h2002, 2'd1, 0, 32'h0000_BEEF, "sh_done");
    chk("sh_nwr", 32'(wa.size()), 2);
    if (wa.size() == 2) begin
      chk("sh_a0", wa[0], 32'h2002); chk("sh_d0", 32'(wd[0]), 32'hEF);
      chk("sh_a1", wa[1], 32'h2003); chk("sh_d1", 32'(wd[1]), 32'hBE);
    end
    do_ls(0, 32'h2002, 2'd1, 0, 32'h0, "lh_done");
`ifdef MEMCTRL_SIGN_EXT_EN
    chk("lh_val", load_val, 32'hFFFF_BEEF);
`else
    chk("lh_val", load_val, 32'h0000_BEEF);
`endif

    // IO store held off by a full UART buffer for three cycles
    wr_cnt = 0; lsf_cnt = 0;
    cyc();
    ls_req(1, 32'h0003_0000, 2'd0, 0, 32'h41);
    io_buffer_full = 1;
    cyc(); cyc(); cyc(); cyc();
    io_buffer_full = 0;
    wait_done("io_done");
    cyc();
    ls_drop();
    cyc(); cyc(); cyc();
    chk("io_nwr", 32'(wr_cnt), 1);
    chk("io_nfin", 32'(lsf_cnt), 1);
    chk("io_byte", 32'(ram_rd(32'h0003_0000)), 32'h41);

    // Fairness: both requesters held, LS issuing back-to-back loads
    dlog.delete();
    cyc();
    if_enable = 1; inst_addr = 32'h100;
    ls_req(0, 32'h100, 2'd2, 1, 32'h0);
    for (int i = 0; i < 200 && dlog.size() < 6; i++) @(negedge clk);
    cyc();
    if_enable = 0; ls_drop();
    order = "LLILLI";
    chk("grant_n", 32'(dlog.size()), 6);
    for (int i = 0; i < 6 && i < dlog.size(); i++) chk("grant_order", 32'(dlog[i]), 32'(order[i]));

    // Flush mid word fetch (idx = 2)
    ifr_cnt = 0;
    ram[32'h200] = 8'h11; ram[32'h201] = 8'h22; ram[32'h202] = 8'h33; ram[32'h203] = 8'h44;
    cyc();
    if_enable = 1; inst_addr = 32'h200;
    cyc(); cyc(); cyc();
    clear = 1; if_enable = 0;
    cyc();
    clear = 0;
    @(negedge clk);
    chk("clr_idle_a", mem_a, 0);
    for (int i = 0; i < 6; i++) cyc();
    chk("clr_no_ifr", 32'(ifr_cnt), 0);
    chk("clr_inst_hold", inst, 32'h0010_0513);

    // Flush mid word store: the store still completes
    wa.delete(); wd.delete(); lsf_cnt = 0;
    cyc();
    ls_req(1, 32'h2100, 2'd2, 0, 32'hDDCC_BBAA);
    cyc(); cyc();
    clear = 1;
    cyc();
    clear = 0;
    wait_done("clrst_done");
    cyc();
    ls_drop();
    chk("clrst_nwr", 32'(wa.size()), 4);
    chk("clrst_word", {ram_rd(32'h2103), ram_rd(32'h2102), ram_rd(32'h2101), ram_rd(32'h2100)},
        32'hDDCC_BBAA);
    chk("clrst_nfin", 32'(lsf_cnt), 1);

    // rdy_in low for four cycles in the middle of a word load
    alog.delete();
    cyc();
    ls_req(0, 32'h100, 2'd2, 1, 32'h0);
    cyc(); cyc(); cyc();
    rdy_in = 0;
    cyc(); cyc(); cyc(); cyc();
    rdy_in = 1;
    wait_done("rdy_done");
    cyc();
    ls_drop();
    chk("rdy_load", load_val, 32'h0010_0513);
    chk("rdy_naddr", 32'(alog.size()), 4);
    for (int i = 0; i < 4 && i < alog.size(); i++) chk("rdy_addr", alog[i], 32'h100 + 32'(i));

    // Reset in the middle of a word store
    cyc();
    ls_req(1, 32'h3000, 2'd2, 0, 32'h1122_3344);
    cyc(); cyc();
    rst_in = 0; ls_drop();
    cyc();
    rst_in = 1;
    @(negedge clk);
    chk("rst2_mem_a", mem_a, 0);
    chk("rst2_mem_wr", 32'(mem_wr), 0);
    chk("rst2_mem_dout", 32'(mem_dout), 0);
    chk("rst2_inst", inst, 0);
    chk("rst2_load", load_val, 0);
    chk("rst2_fin", 32'(ls_finished), 0);
    cyc(); cyc();
    @(negedge clk);
    chk("rst2_idle_a", mem_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
